// File: rtl/rx_byte_assembler_pkg.sv
// Shared types and defaults for the USB RX byte assembler slice.
package usb_rx_pkg;
  typedef enum logic [1:0] {IDLE, RECEIVE, ERROR} rx_asm_state_t;

  localparam int STUFF_RUN_DEF = 6;
  localparam int DATA_W_DEF    = 8;
endpackage

// File: rtl/rx_byte_assembler_if.sv
// Decoder/controller-facing bundle of the RX byte assembler.
interface rx_byte_assembler_if import usb_rx_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
);
  logic              d_orig;
  logic              shift_enable;
  logic              eop_detected;
  logic              rcv_enable;
  logic [DATA_W-1:0] rx_data;
  logic              byte_valid;
  logic              stuff_error;
  logic              align_error;
  logic              busy;

  modport master (
    output d_orig, shift_enable, eop_detected, rcv_enable,
    input  rx_data, byte_valid, stuff_error, align_error, busy
  );

  modport slave (
    input  d_orig, shift_enable, eop_detected, rcv_enable,
    output rx_data, byte_valid, stuff_error, align_error, busy
  );
endinterface

// File: rtl/rx_byte_assembler_unstuff.sv
// Tracks the run of consecutive 1s and decodes stuff-bit discard / stuff error.
module rx_unstuff_counter import usb_rx_pkg::*; #(
  parameter int STUFF_RUN = STUFF_RUN_DEF
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic sample,
  input  logic d_bit,
  output logic discard,
  output logic stuff_err
);
  localparam int CW = $clog2(STUFF_RUN + 1);

  logic [CW-1:0] ones_cnt;
  logic          at_run;

  assign at_run    = (ones_cnt == CW'(STUFF_RUN));
  assign discard   = sample && at_run;
  assign stuff_err = discard && d_bit;

  // The stuff slot always restarts the run, so the count never passes STUFF_RUN.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ones_cnt <= '0;
    end else if (clear) begin
      ones_cnt <= '0;
    end else if (sample) begin
      if (at_run || !d_bit) ones_cnt <= '0;
      else                  ones_cnt <= ones_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/rx_byte_assembler.sv
// Unstuffs decoded USB bits, assembles LSB-first words and flags stuff/alignment errors.
module rx_byte_assembler import usb_rx_pkg::*; #(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int STUFF_RUN = STUFF_RUN_DEF
) (
  input logic                clk,
  input logic                n_rst,
  rx_byte_assembler_if.slave bus
);
  localparam int BW = $clog2(DATA_W);

  rx_asm_state_t     state;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_next;
  logic [BW-1:0]     bit_cnt;
  logic              sample;
  logic              clear;
  logic              discard;
  logic              stuff_err;

  // A bit arriving as rcv_enable drops is not a sample event, so it cannot raise a pulse.
  assign sample     = bus.shift_enable && (state == RECEIVE) && !bus.eop_detected && bus.rcv_enable;
  assign clear      = (state == IDLE) && bus.rcv_enable;
  assign shift_next = {bus.d_orig, shift_reg[DATA_W-1:1]};

  rx_unstuff_counter #(.STUFF_RUN(STUFF_RUN)) u_unstuff (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (clear),
    .sample    (sample),
    .d_bit     (bus.d_orig),
    .discard   (discard),
    .stuff_err (stuff_err)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state           <= IDLE;
      shift_reg       <= '0;
      bit_cnt         <= '0;
      bus.rx_data     <= '0;
      bus.byte_valid  <= 1'b0;
      bus.stuff_error <= 1'b0;
      bus.align_error <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      bus.byte_valid  <= 1'b0;
      bus.stuff_error <= 1'b0;
      bus.align_error <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.rcv_enable) begin
            state     <= RECEIVE;
            bus.busy  <= 1'b1;
            shift_reg <= '0;
            bit_cnt   <= '0;
          end
        end
        RECEIVE: begin
          if (bus.eop_detected) begin
            // Partial word at EOP is dropped and reported.
            bus.align_error <= (bit_cnt != '0);
            state           <= IDLE;
            bus.busy        <= 1'b0;
          end else if (!bus.rcv_enable) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else if (stuff_err) begin
            bus.stuff_error <= 1'b1;
            state           <= ERROR;
            bus.busy        <= 1'b0;
          end else if (sample && !discard) begin
            shift_reg <= shift_next;
            if (bit_cnt == BW'(DATA_W - 1)) begin
              bit_cnt        <= '0;
              bus.rx_data    <= shift_next;
              bus.byte_valid <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ERROR: begin
          if (!bus.rcv_enable) state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
